d8_mul_seq: RTL and testbench



---
 rtl/d8_mul_seq.sv | 128 ++++++++++++
 tb/tb_d8_mul_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/d8_mul_seq.sv
// Sequential 8x8->16 unsigned shift-and-add multiplier borrowing the shared 8-bit ALU.
// Optional early termination on an all-zero remaining multiplier: define D8_MUL_EARLY_EXIT_EN.
module d8_mul_seq #(
    parameter int unsigned DONE_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clr,
    input  logic [7:0]  mcand,
    input  logic [7:0]  mplier,
    output logic        busy,
    output logic        done,
    output logic [15:0] prod,
    input  logic [2:0]  cpu_ctrl_alu,
    input  logic [7:0]  cpu_a,
    input  logic [7:0]  cpu_b,
    output logic [2:0]  alu_ctrl_alu,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_s,
    input  logic        alu_c
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [7:0]  mc_q, mc_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] prod_q, prod_d;
    logic        done_q, done_d;

`ifdef D8_MUL_EARLY_EXIT_EN
    logic [7:0]  remain_mask;
    logic [3:0]  exit_shamt;
    logic [15:0] exit_prod;

    // lo[7-cnt:0] still holds unconsumed multiplier bits; the rest is product.
    assign remain_mask = 8'hFF >> cnt_q;
    assign exit_shamt  = 4'd8 - {1'b0, cnt_q};
    assign exit_prod   = {hi_q, lo_q} >> exit_shamt;
`endif

    always_comb begin
        state_d      = state_q;
        mc_d         = mc_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        cnt_d        = cnt_q;
        prod_d       = prod_q;
        done_d       = (DONE_HOLD != 0) ? done_q : 1'b0;
        alu_ctrl_alu = cpu_ctrl_alu;
        alu_a        = cpu_a;
        alu_b        = cpu_b;

        if (state_q == StRun) begin
            alu_ctrl_alu = 3'b001;
            alu_a        = hi_q;
            alu_b        = lo_q[0] ? mc_q : 8'h00;
        end

        if (clr) begin
            state_d = StIdle;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mc_d    = mcand;
                        hi_d    = 8'h00;
                        lo_d    = mplier;
                        cnt_d   = 3'd0;
                        done_d  = 1'b0;
                        state_d = StRun;
                    end
                end
                StRun: begin
`ifdef D8_MUL_EARLY_EXIT_EN
                    if ((lo_q & remain_mask) == 8'h00) begin
                        prod_d  = exit_prod;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else
`endif
                    begin
                        // 9-bit sum shifted right one place keeps the carry.
                        hi_d  = {alu_c, alu_s[7:1]};
                        lo_d  = {alu_s[0], lo_q[7:1]};
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            prod_d  = {alu_c, alu_s, lo_q[7:1]};
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mc_q    <= 8'h00;
            hi_q    <= 8'h00;
            lo_q    <= 8'h00;
            cnt_q   <= 3'd0;
            prod_q  <= 16'h0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mc_q    <= mc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;
    assign prod = prod_q;

endmodule

// File: tb/tb_d8_mul_seq.sv
// Directed self-checking bench for d8_mul_seq with a behavioural model of the shared ALU.
module tb_d8_mul_seq;

    localparam int unsigned DoneHold = 1;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clr;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        busy;
    logic        done;
    logic [15:0] prod;
    logic [2:0]  cpu_ctrl_alu;
    logic [7:0]  cpu_a;
    logic [7:0]  cpu_b;
    logic [2:0]  alu_ctrl_alu;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_s;
    logic        alu_c;

    int n_assert = 0;
    int n_fail   = 0;

    d8_mul_seq #(.DONE_HOLD(DoneHold)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .clr          (clr),
        .mcand        (mcand),
        .mplier       (mplier),
        .busy         (busy),
        .done         (done),
        .prod         (prod),
        .cpu_ctrl_alu (cpu_ctrl_alu),
        .cpu_a        (cpu_a),
        .cpu_b        (cpu_b),
        .alu_ctrl_alu (alu_ctrl_alu),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_s        (alu_s),
        .alu_c        (alu_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU model.
    always_comb begin
        {alu_c, alu_s} = 9'h000;
        case (alu_ctrl_alu)
            3'b001:  {alu_c, alu_s} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b010:  {alu_c, alu_s} = {1'b0, alu_a} - {1'b0, alu_b};
            3'b011:  {alu_c, alu_s} = {alu_a, 1'b0};
            3'b100:  {alu_c, alu_s} = {alu_a[0], 1'b0, alu_a[7:1]};
            default: {alu_c, alu_s} = 9'h000;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Number of RUN cycles for a given multiplier.
    function automatic int run_len(input logic [7:0] mp);
`ifdef D8_MUL_EARLY_EXIT_EN
        int top;
        top = -1;
        for (int i = 0; i < 8; i++) if (mp[i]) top = i;
        return (top + 2 > 8) ? 8 : top + 2;
`else
        return 8;
`endif
    endfunction

    task automatic check_idle_mux();
        chk("idle_alu_ctrl", {13'h0, alu_ctrl_alu}, {13'h0, cpu_ctrl_alu});
        chk("idle_alu_a", {8'h0, alu_a}, {8'h0, cpu_a});
        chk("idle_alu_b", {8'h0, alu_b}, {8'h0, cpu_b});
    endtask

    // Full multiply; optional ignored start pulse in RUN cycle inj_k (0 = none).
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp, input int inj_k);
        int len;
        len = run_len(b);
        @(negedge clk);
        mcand = a; mplier = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= len; k++) begin
            chk("run_busy", {15'h0, busy}, 16'h0001);
            chk("run_done", {15'h0, done}, 16'h0000);
            chk("run_alu_ctrl", {13'h0, alu_ctrl_alu}, 16'h0001);
            if (k == 1) begin
                chk("run_alu_a0", {8'h0, alu_a}, 16'h0000);
                chk("run_alu_b0", {8'h0, alu_b}, {8'h0, (b[0] ? a : 8'h00)});
            end
            if (k == inj_k) begin
                start = 1'b1; mcand = 8'h05; mplier = 8'h05;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("end_busy", {15'h0, busy}, 16'h0000);
        chk("end_done", {15'h0, done}, 16'h0001);
        chk("end_prod", prod, exp);
        check_idle_mux();
        @(negedge clk);
        chk("done_after", {15'h0, done}, (DoneHold != 0) ? 16'h0001 : 16'h0000);
        chk("prod_hold", prod, exp);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; clr = 1'b0; mcand = 8'h00; mplier = 8'h00;
        cpu_ctrl_alu = 3'b001; cpu_a = 8'h12; cpu_b = 8'h34;
        #1;
        chk("rst_busy", {15'h0, busy}, 16'h0000);
        chk("rst_done", {15'h0, done}, 16'h0000);
        chk("rst_prod", prod, 16'h0000);
        check_idle_mux();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", {15'h0, busy}, 16'h0000);
        chk("idle_prod", prod, 16'h0000);
        cpu_ctrl_alu = 3'b010; cpu_a = 8'hA7; cpu_b = 8'h3C;
        #1;
        check_idle_mux();

        run_mul(8'h0D, 8'h0B, 16'h008F, 0);
        run_mul(8'hFF, 8'hFF, 16'hFE01, 0);
        run_mul(8'h00, 8'hA5, 16'h0000, 0);
        run_mul(8'h00, 8'h00, 16'h0000, 0);
        run_mul(8'h02, 8'h80, 16'h0100, 0);
        run_mul(8'h03, 8'h04, 16'h000C, 3);

        // Abort with clr in RUN cycle T+4.
        @(negedge clk);
        mcand = 8'h10; mplier = 8'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("clr_run_busy", {15'h0, busy}, 16'h0001);
            if (k == 4) clr = 1'b1;
            @(negedge clk);
        end
        clr = 1'b0;
        chk("clr_busy", {15'h0, busy}, 16'h0000);
        chk("clr_done", {15'h0, done}, 16'h0000);
        chk("clr_prod", prod, 16'h000C);
        repeat (8) @(negedge clk);
        chk("clr_no_done", {15'h0, done}, 16'h0000);
        chk("clr_prod_kept", prod, 16'h000C);
        run_mul(8'h02, 8'h03, 16'h0006, 0);

        // Asynchronous reset in RUN cycle T+5.
        @(negedge clk);
        mcand = 8'h20; mplier = 8'h20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", {15'h0, busy}, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_prod", prod, 16'h0000);
        chk("arst_busy", {15'h0, busy}, 16'h0000);
        chk("arst_done", {15'h0, done}, 16'h0000);
        check_idle_mux();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_done", {15'h0, done}, 16'h0000);
        chk("post_rst_prod", prod, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
